// File: rtl/ibex_multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package ibex_multdiv_pkg;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_MULH = 2'd1,
    MD_DIV  = 2'd2,
    MD_REM  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_iter_state_e;

  // Number of ITER cycles needed to retire all WIDTH result bits.
  function automatic int md_num_iter(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/ibex_multdiv_iter_step.sv
// One radix-2 step: a conditional partial-product add and a restoring
// trial subtract. Both are evaluated; the parent keeps whichever its op needs.
module ibex_multdiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_addend,
  input  logic               i_mul_bit,
  input  logic [WIDTH:0]     i_rem,
  input  logic               i_din_bit,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH:0]     o_rem,
  output logic               o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // Partial-product accumulate and shift-in/trial-subtract; borrow out of the MSB means "does not fit".
  always_comb begin
    o_acc   = i_mul_bit ? (i_acc + i_addend) : i_acc;
    w_shift = {i_rem, i_din_bit};
    w_diff  = w_shift - {2'b00, i_divisor};
    o_qbit  = ~w_diff[WIDTH+1];
    o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide unit: magnitude datapath, sign fix-up at the end,
// BITS_PER_CYCLE chained steps per ITER cycle, optional data-dependent early out.
module ibex_multdiv_iter
  import ibex_multdiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_OUT      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = md_num_iter(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(N) + 1;

  md_iter_state_e     r_state;
  md_op_e             r_op;
  logic [1:0]         r_sm;
  logic               r_dit;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_opa;     // raw a, then |a|, then dividend shifted MSB-first
  logic [WIDTH-1:0]   r_opb;     // raw b, then |b|: multiplier (shifted) or divisor (held)
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;

  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_is_mul;
  logic               w_shortcut_ok;
  logic [WIDTH-1:0]   w_mplier_nxt;
  logic [BPC-1:0]     w_qbits;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_rem_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_fix_result;

  function automatic logic [WIDTH-1:0] f_cneg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign w_sign_a      = r_opa[WIDTH-1] & r_sm[0];
  assign w_sign_b      = r_opb[WIDTH-1] & r_sm[1];
  assign w_mag_a       = f_cneg_w(r_opa, w_sign_a);
  assign w_mag_b       = f_cneg_w(r_opb, w_sign_b);
  assign w_is_mul      = (r_op == MD_MUL) || (r_op == MD_MULH);
  assign w_shortcut_ok = EARLY_OUT && !r_dit;
  assign w_mplier_nxt  = r_opb >> BPC;

  for (genvar k = 0; k < BPC; k++) begin : g_step
    logic [2*WIDTH-1:0] w_acc_in;
    logic [2*WIDTH-1:0] w_acc_out;
    logic [WIDTH:0]     w_rem_in;
    logic [WIDTH:0]     w_rem_out;
    logic               w_qbit;
    if (k == 0) begin : g_head
      assign w_acc_in = r_acc;
      assign w_rem_in = r_rem;
    end else begin : g_link
      assign w_acc_in = g_step[k-1].w_acc_out;
      assign w_rem_in = g_step[k-1].w_rem_out;
    end
    ibex_multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .i_acc     (w_acc_in),
      .i_addend  (r_mcand << k),
      .i_mul_bit (r_opb[k]),
      .i_rem     (w_rem_in),
      .i_din_bit (r_opa[WIDTH-1-k]),
      .i_divisor (r_opb),
      .o_acc     (w_acc_out),
      .o_rem     (w_rem_out),
      .o_qbit    (w_qbit)
    );
    assign w_qbits[BPC-1-k] = w_qbit;
  end

  assign w_acc_nxt = g_step[BPC-1].w_acc_out;
  assign w_rem_nxt = g_step[BPC-1].w_rem_out;

  // Sign fix-up and result word select; a zero divisor keeps the all-ones quotient unsigned.
  always_comb begin
    w_prod    = f_cneg_2w(r_acc, r_sign_a ^ r_sign_b);
    w_quo_fix = f_cneg_w(r_quo, (r_sign_a ^ r_sign_b) && (r_opb != '0));
    w_rem_fix = f_cneg_w(r_rem[WIDTH-1:0], r_sign_a);
    case (r_op)
      MD_MUL:  w_fix_result = w_prod[WIDTH-1:0];
      MD_MULH: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
      MD_DIV:  w_fix_result = w_quo_fix;
      default: w_fix_result = w_rem_fix;
    endcase
  end

  // Control FSM and datapath registers; kill returns to IDLE from any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_op     <= MD_MUL;
      r_sm     <= '0;
      r_dit    <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (kill_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_op    <= md_op_e'(op_i);
            r_sm    <= signed_mode_i;
            r_opa   <= op_a_i;
            r_opb   <= op_b_i;
            r_dit   <= data_ind_timing_i;
            r_state <= PREP;
          end
        end
        PREP: begin
          r_sign_a <= w_sign_a;
          r_sign_b <= w_sign_b;
          r_opa    <= w_mag_a;
          r_opb    <= w_mag_b;
          r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
          r_acc    <= '0;
          r_rem    <= '0;
          r_quo    <= '0;
          r_cnt    <= CNT_W'(N - 1);
          // Zero b: the product is 0, and division lands where the full iteration would.
          if (w_shortcut_ok && (r_opb == '0)) begin
            if (!w_is_mul) begin
              r_quo <= '1;
              r_rem <= {1'b0, w_mag_a};
            end
            r_state <= FIX;
          end else begin
            r_state <= ITER;
          end
        end
        ITER: begin
          if (w_is_mul) begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << BPC;
            r_opb   <= w_mplier_nxt;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[WIDTH-1-BPC:0], w_qbits};
            r_opa <= r_opa << BPC;
          end
          r_cnt <= r_cnt - 1'b1;
          if ((r_cnt == '0) || (w_shortcut_ok && w_is_mul && (w_mplier_nxt == '0))) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= w_fix_result;
          r_state  <= DONE;
        end
        DONE: begin
          if (resp_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign resp_valid_o = (r_state == DONE);
  assign result_o     = r_result;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Bench for ibex_multdiv_iter: three configurations (32/1, 16/2, 16/4) behind one
// selectable port view, directed vectors, handshake/kill/reset sequences, random ops.
module tb_ibex_multdiv_iter;

  localparam int LAT_MAX = 200;
  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  op;
  logic [1:0]  sm;
  logic [31:0] a;
  logic [31:0] b;
  logic        dit;
  logic        kill;
  logic        resp_ready;
  int          sel;

  logic [2:0]  rv;
  logic [2:0]  ready_v;
  logic [2:0]  valid_v;
  logic [2:0]  busy_v;
  logic [31:0] res0;
  logic [15:0] res1;
  logic [15:0] res2;

  logic        m_valid;
  logic        m_ready;
  logic        m_busy;
  logic [31:0] m_result;

  int n_tests = 0;
  int n_fail  = 0;
  int cfg_w   [3] = '{32, 16, 16};
  int cfg_bpc [3] = '{1, 2, 4};

  always #5 clk = ~clk;

  assign rv[0] = req_valid && (sel == 0);
  assign rv[1] = req_valid && (sel == 1);
  assign rv[2] = req_valid && (sel == 2);

  ibex_multdiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[0]), .req_ready_o(ready_v[0]),
    .op_i(op), .signed_mode_i(sm), .op_a_i(a), .op_b_i(b), .data_ind_timing_i(dit),
    .kill_i(kill), .resp_valid_o(valid_v[0]), .resp_ready_i(resp_ready),
    .result_o(res0), .busy_o(busy_v[0]));

  ibex_multdiv_iter #(.WIDTH(16), .BITS_PER_CYCLE(2), .EARLY_OUT(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[1]), .req_ready_o(ready_v[1]),
    .op_i(op), .signed_mode_i(sm), .op_a_i(a[15:0]), .op_b_i(b[15:0]), .data_ind_timing_i(dit),
    .kill_i(kill), .resp_valid_o(valid_v[1]), .resp_ready_i(resp_ready),
    .result_o(res1), .busy_o(busy_v[1]));

  ibex_multdiv_iter #(.WIDTH(16), .BITS_PER_CYCLE(4), .EARLY_OUT(1'b1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[2]), .req_ready_o(ready_v[2]),
    .op_i(op), .signed_mode_i(sm), .op_a_i(a[15:0]), .op_b_i(b[15:0]), .data_ind_timing_i(dit),
    .kill_i(kill), .resp_valid_o(valid_v[2]), .resp_ready_i(resp_ready),
    .result_o(res2), .busy_o(busy_v[2]));

  // Present the selected configuration's outputs, results zero-extended to 32 bits.
  always_comb begin
    m_valid  = valid_v[0];
    m_ready  = ready_v[0];
    m_busy   = busy_v[0];
    m_result = res0;
    case (sel)
      1: begin m_valid = valid_v[1]; m_ready = ready_v[1]; m_busy = busy_v[1]; m_result = {16'h0, res1}; end
      2: begin m_valid = valid_v[2]; m_ready = ready_v[2]; m_busy = busy_v[2]; m_result = {16'h0, res2}; end
      default: ;
    endcase
  end

  // Reference result from plain signed/unsigned integer arithmetic at width w.
  function automatic logic [31:0] ref_result(input int w, input logic [1:0] o, input logic [1:0] s,
                                             input logic [31:0] ai, input logic [31:0] bi);
    logic [31:0] mask, am, bm;
    longint      sa, sb, q, r;
    logic [63:0] p;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am = ai & mask;
    bm = bi & mask;
    sa = (s[0] && am[w-1]) ? longint'(am) - (longint'(1) << w) : longint'(am);
    sb = (s[1] && bm[w-1]) ? longint'(bm) - (longint'(1) << w) : longint'(bm);
    case (o)
      OP_MUL:  begin p = sa * sb; return p[31:0] & mask; end
      OP_MULH: begin p = sa * sb; p = p >> w; return p[31:0] & mask; end
      OP_DIV: begin
        if (bm == 0) return mask;
        q = sa / sb; p = q; return p[31:0] & mask;
      end
      default: begin
        if (bm == 0) return am;
        r = sa % sb; p = r; return p[31:0] & mask;
      end
    endcase
  endfunction

  // Reference latency: N+2, or shortened by the multiplier's bit length / zero divisor.
  function automatic int ref_latency(input int w, input int bpc, input logic [1:0] o, input logic [1:0] s,
                                     input logic [31:0] bi, input logic d);
    int n, bl;
    logic [31:0] mask, bm, mb;
    n = w / bpc;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bm = bi & mask;
    if (d) return n + 2;
    if (bm == 0) return 2;
    if (o == OP_DIV || o == OP_REM) return n + 2;
    mb = (s[1] && bm[w-1]) ? ((~bm + 32'd1) & mask) : bm;
    bl = 0;
    for (int i = 0; i < w; i++) if (mb[i]) bl = i + 1;
    return (bl + bpc - 1) / bpc + 2;
  endfunction

  function automatic logic [31:0] pick_operand(input int w);
    logic [31:0] mask, v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1 << (w - 1);
      4: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v & mask;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input int s, input logic [1:0] o, input logic [1:0] smi,
                          input logic [31:0] ai, input logic [31:0] bi, input logic d);
    @(negedge clk);
    sel = s; op = o; sm = smi; a = ai; b = bi; dit = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op = 2'($urandom); sm = 2'($urandom); a = $urandom; b = $urandom; dit = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < LAT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!m_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no resp_valid within %0d cycles", LAT_MAX);
    end
  endtask

  task automatic run_op(input int s, input logic [1:0] o, input logic [1:0] smi,
                        input logic [31:0] ai, input logic [31:0] bi, input logic d,
                        output logic [31:0] res, output int lat);
    start_op(s, o, smi, ai, bi, d);
    wait_valid(lat);
    res = m_result;
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    int          cfg;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic        dit;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] res;
  int          lat;
  logic        seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"mul_ss",        0, OP_MUL,  2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 34});
    vecs.push_back('{"mulh_ss",       0, OP_MULH, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"mulh_uu",       0, OP_MULH, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'h0000_0006, 34});
    vecs.push_back('{"mul_ss_early",  0, OP_MUL,  2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 4});
    vecs.push_back('{"div_ss",        0, OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 34});
    vecs.push_back('{"rem_ss",        0, OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"div_uu",        0, OP_DIV,  2'b00, 32'd100,       32'd7,         1'b1, 32'd14,        34});
    vecs.push_back('{"rem_uu",        0, OP_REM,  2'b00, 32'd100,       32'd7,         1'b1, 32'd2,         34});
    vecs.push_back('{"div0_fast",     0, OP_DIV,  2'b11, 32'h0000_1234, 32'h0,         1'b0, 32'hFFFF_FFFF, 2});
    vecs.push_back('{"rem0_fast",     0, OP_REM,  2'b11, 32'h0000_1234, 32'h0,         1'b0, 32'h0000_1234, 2});
    vecs.push_back('{"div0_fixed",    0, OP_DIV,  2'b11, 32'h0000_1234, 32'h0,         1'b1, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"rem0_fixed",    0, OP_REM,  2'b11, 32'h0000_1234, 32'h0,         1'b1, 32'h0000_1234, 34});
    vecs.push_back('{"div_ovf",       0, OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 34});
    vecs.push_back('{"rem_ovf",       0, OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 34});
    vecs.push_back('{"mul_early_5x1", 0, OP_MUL,  2'b00, 32'd5,         32'd1,         1'b0, 32'd5,         3});
    vecs.push_back('{"w16b2_div_ovf", 1, OP_DIV,  2'b11, 32'h0000_8000, 32'h0000_FFFF, 1'b1, 32'h0000_8000, 10});
    vecs.push_back('{"w16b2_mulh_uu", 1, OP_MULH, 2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0000_FFFE, 10});
    vecs.push_back('{"w16b4_rem_ss",  2, OP_REM,  2'b11, 32'h0000_FFF9, 32'h0000_0002, 1'b1, 32'h0000_FFFF, 6});
    vecs.push_back('{"w16b4_mul_eo",  2, OP_MUL,  2'b00, 32'h0000_0003, 32'h0000_0010, 1'b0, 32'h0000_0030, 4});

    rst_n = 1'b0; req_valid = 1'b0; op = '0; sm = '0; a = '0; b = '0; dit = 1'b0;
    kill = 1'b0; resp_ready = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check($sformatf("reset_ready_%0d", s), 32'(m_ready), 32'd1);
      check($sformatf("reset_valid_%0d", s), 32'(m_valid), 32'd0);
      check($sformatf("reset_busy_%0d", s), 32'(m_busy), 32'd0);
      check($sformatf("reset_result_%0d", s), m_result, 32'd0);
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].cfg, vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].dit, res, lat);
      check({vecs[i].name, "_res"}, res, vecs[i].exp_res);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: result and handshake outputs hold while the consumer stalls.
    resp_ready = 1'b0;
    start_op(0, OP_DIV, 2'b00, 32'd100, 32'd7, 1'b1);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd34);
    check("bp_res", m_result, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_hold_result", m_result, 32'd14);
      check("bp_hold_ready", 32'(m_ready), 32'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(m_ready), 32'd1);
    check("bp_release_valid", 32'(m_valid), 32'd0);

    // Kill mid-ITER: back to IDLE at once, no response, then a clean follow-up request.
    start_op(0, OP_MUL, 2'b00, 32'd7, 32'd3, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check("kill_iter_busy", 32'(m_busy), 32'd0);
    check("kill_iter_ready", 32'(m_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m_valid) seen = 1'b1;
    end
    check("kill_iter_no_resp", 32'(seen), 32'd0);
    run_op(0, OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat);
    check("after_kill_res", res, 32'hFFFF_FFFD);
    check("after_kill_lat", 32'(lat), 32'd34);

    // Kill in DONE drops the pending result.
    resp_ready = 1'b0;
    start_op(0, OP_MUL, 2'b00, 32'd5, 32'd1, 1'b0);
    wait_valid(lat);
    check("kill_done_pre_valid", 32'(m_valid), 32'd1);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check("kill_done_valid", 32'(m_valid), 32'd0);
    check("kill_done_ready", 32'(m_ready), 32'd1);
    resp_ready = 1'b1;

    // Kill in IDLE blocks acceptance.
    @(negedge clk);
    sel = 0; op = OP_MUL; a = 32'd3; b = 32'd3; dit = 1'b1; req_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0;
    check("kill_idle_busy", 32'(m_busy), 32'd0);

    // Asynchronous reset mid-operation clears state and result.
    start_op(0, OP_DIV, 2'b00, 32'd100, 32'd7, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_mid_busy", 32'(m_busy), 32'd0);
    check("rst_mid_ready", 32'(m_ready), 32'd1);
    check("rst_mid_result", m_result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Random operations on every configuration against the arithmetic model.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 50; i++) begin
        logic [1:0]  ro, rs;
        logic [31:0] ra, rb;
        logic        rd;
        ro = 2'($urandom); rs = 2'($urandom); rd = 1'($urandom);
        ra = pick_operand(cfg_w[s]); rb = pick_operand(cfg_w[s]);
        run_op(s, ro, rs, ra, rb, rd, res, lat);
        check($sformatf("rand_res_c%0d_op%0d_sm%0d_a%08h_b%08h", s, ro, rs, ra, rb),
              res, ref_result(cfg_w[s], ro, rs, ra, rb));
        check($sformatf("rand_lat_c%0d_op%0d_sm%0d_b%08h_d%0d", s, ro, rs, rb, rd),
              32'(lat), 32'(ref_latency(cfg_w[s], cfg_bpc[s], ro, rs, rb, rd)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
